// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache controller: fixed-latency block reads (16-beat bursts)
// and block write-backs. Optional upper-address bounds checking under MEM_BOUNDS_CHECK_EN.
module cache_mem_responder #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_OFFSET     = 4,
  parameter int BLOCK_DATA_WIDTH = WORD_SIZE << BLOCK_OFFSET,
  parameter int MEM_BLOCK_BITS   = 8,
  parameter int MEM_BLOCKS       = 2 ** MEM_BLOCK_BITS,
  parameter int LATENCY          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req_enable,
  input  logic                        mem_req_rw,
  input  logic [WORD_SIZE-1:0]        mem_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
  output logic [WORD_SIZE-1:0]        mem_req_datain,
  output logic                        mem_req_ready,
  output logic                        mem_resp_last,
  output logic                        mem_resp_err,
  output logic                        mem_busy
);
  // state        | meaning
  // S_IDLE       | waiting for a request strobe
  // S_WAIT       | access latency countdown
  // S_READ       | streaming read beats, word 0 first
  // S_COMMIT     | single-cycle write-back commit
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_COMMIT} state_t;

  localparam int IDX_LSB = BLOCK_OFFSET + 2;
  localparam logic [BLOCK_OFFSET-1:0] LAST_BEAT = '1;

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [BLOCK_OFFSET-1:0]     beat_q, beat_d, beat_nx;
  logic                        rw_q, oob_q, oob_in;
  logic [MEM_BLOCK_BITS-1:0]   idx_q;
  logic [BLOCK_DATA_WIDTH-1:0] blk_q, rd_blk;
  logic [WORD_SIZE-1:0]        data_d;
  logic                        ready_d, last_d, err_d, accept, commit;

  logic [BLOCK_DATA_WIDTH-1:0] mem [MEM_BLOCKS];

  function automatic logic [WORD_SIZE-1:0] word_of(input logic [BLOCK_DATA_WIDTH-1:0] b,
                                                   input logic [BLOCK_OFFSET-1:0] k);
    word_of = b[BLOCK_DATA_WIDTH-1-int'(k)*WORD_SIZE -: WORD_SIZE];
  endfunction

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_in = |mem_req_addr[WORD_SIZE-1:IDX_LSB+MEM_BLOCK_BITS];
`else
  assign oob_in = 1'b0;
`endif

  assign rd_blk  = mem[idx_q];
  assign beat_nx = beat_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    ready_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_enable) begin
          accept  = 1'b1;
          cnt_d   = 8'(LATENCY);
          beat_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Terminal count 1 so the first response lands on the LATENCY-th edge.
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          err_d   = oob_q;
          if (rw_q) begin
            last_d  = 1'b1;
            state_d = S_COMMIT;
          end else begin
            beat_d  = '0;
            last_d  = (beat_d == LAST_BEAT);
            data_d  = oob_q ? '0 : word_of(rd_blk, '0);
            state_d = S_READ;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_READ: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_nx;
          ready_d = 1'b1;
          err_d   = oob_q;
          last_d  = (beat_nx == LAST_BEAT);
          data_d  = oob_q ? '0 : word_of(rd_blk, beat_nx);
        end
      end
      S_COMMIT: begin
        commit  = !oob_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      beat_q         <= '0;
      rw_q           <= 1'b0;
      oob_q          <= 1'b0;
      idx_q          <= '0;
      blk_q          <= '0;
      mem_req_datain <= '0;
      mem_req_ready  <= 1'b0;
      mem_resp_last  <= 1'b0;
      mem_resp_err   <= 1'b0;
      mem_busy       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      beat_q         <= beat_d;
      mem_req_datain <= data_d;
      mem_req_ready  <= ready_d;
      mem_resp_last  <= last_d;
      mem_resp_err   <= err_d;
      mem_busy       <= (state_d != S_IDLE);
      if (accept) begin
        rw_q  <= mem_req_rw;
        oob_q <= oob_in;
        idx_q <= mem_req_addr[IDX_LSB +: MEM_BLOCK_BITS];
        if (mem_req_rw) blk_q <= mem_req_dataout;
      end
    end
  end

  // Backing array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit) mem[idx_q] <= blk_q;
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: expected beats queued at stimulus, compared to
// beats captured from the DUT, including beat timing relative to request acceptance.
module tb_cache_mem_responder;
  localparam int LAT = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
    logic [31:0] cyc;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         rw = 1'b0;
  logic [31:0]  addr = '0;
  logic [511:0] dout = '0;
  logic [31:0]  datain;
  logic         ready, last, err, busy;

  cache_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_req_enable(en), .mem_req_rw(rw),
    .mem_req_addr(addr), .mem_req_dataout(dout), .mem_req_datain(datain),
    .mem_req_ready(ready), .mem_resp_last(last), .mem_resp_err(err), .mem_busy(busy)
  );

  always #5 clk = ~clk;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  int           idle_bad = 0;
  beat_t        exp_q[$];
  beat_t        obs_q[$];
  logic [511:0] model [int];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ready) obs_q.push_back('{datain, last, err, 32'(cyc)});
      else if (datain !== 32'd0 || last !== 1'b0 || err !== 1'b0) idle_bad++;
    end
  end

  function automatic logic [511:0] mk_blk(input logic [31:0] seed);
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511-32*k -: 32] = seed + 32'(k) * 32'h0101_0101;
    return b;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[13:6]);
  endfunction

  task automatic issue(input logic r, input logic [31:0] a, input logic [511:0] b, output int acc);
    @(negedge clk);
    en = 1'b1; rw = r; addr = a; dout = b;
    @(posedge clk);
    #1 acc = cyc;
    en = 1'b0;
  endtask

  task automatic push_read(input logic [31:0] a, input int acc, input bit oob);
    logic [511:0] b;
    b = oob ? '0 : model[idx_of(a)];
    for (int k = 0; k < 16; k++)
      exp_q.push_back('{b[511-32*k -: 32], (k == 15), oob, 32'(acc + LAT + k)});
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({ready, last, err, busy, datain} !== 36'd0)
      $display("FAIL reset_outputs: got %h want 0", {ready, last, err, busy, datain});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({ready, last, err, busy, datain} !== 36'd0 || obs_q.size() != 0)
      $display("FAIL reset_idle: got %h beats %0d want 0", {ready, last, err, busy, datain}, obs_q.size());
    else n_pass++;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [511:0] b, input string name);
    int acc; bit ok; beat_t e, o;
    issue(1'b1, a, b, acc);
    model[idx_of(a)] = b;
    exp_q.push_back('{32'd0, 1'b1, 1'b0, 32'(acc + LAT)});
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", name, busy);
    else n_pass++;
    wait_obs(1, ok);
    n_checks++;
    if (!ok) $display("FAIL %s_timeout: got no ready want 1 pulse", name);
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL %s_pulse: got %h want %h", name, o, e);
      else n_pass++;
    end
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || obs_q.size() != 0)
      $display("FAIL %s_after: busy %b beats %0d want 0 0", name, busy, obs_q.size());
    else n_pass++;
  endtask

  task automatic do_read(input logic [31:0] a, input bit oob, input bit poke, input string name);
    int acc, acc2; bit ok; beat_t e, o;
    issue(1'b0, a, '0, acc);
    push_read(a, acc, oob);
    if (poke) begin
      repeat (LAT + 3) @(negedge clk);
      issue(1'b1, 32'h0000_0080, mk_blk(32'hDEAD_0000), acc2);
    end
    wait_obs(16, ok);
    n_checks++;
    if (!ok) $display("FAIL %s_timeout: got %0d beats want 16", name, obs_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL %s_beat: got %h want %h", name, o, e);
      else n_pass++;
    end
    exp_q.delete();
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0)
      $display("FAIL %s_extra: beats %0d busy %b want 0 0", name, obs_q.size(), busy);
    else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_write;
    do_write(32'h0000_0040, {32'hCAFE_FACE, 480'd0}, "write_b1");
  endtask

  task automatic test_read;
    do_read(32'h0000_0040, 1'b0, 1'b0, "read_b1");
  endtask

  task automatic test_back_to_back;
    do_write(32'h0000_0080, mk_blk(32'h1234_5600), "write_b2");
    do_read(32'h0000_0040, 1'b0, 1'b1, "read_poke");
    do_read(32'h0000_0080, 1'b0, 1'b0, "read_b2");
  endtask

  task automatic test_reset_during_wait;
    int acc;
    issue(1'b1, 32'h0000_0080, mk_blk(32'hBAD0_0000), acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, last, err, busy, datain} !== 36'd0)
      $display("FAIL abort_outputs: got %h want 0", {ready, last, err, busy, datain});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL abort_pulse: got %0d beats want 0", obs_q.size());
    else n_pass++;
    obs_q.delete();
    do_read(32'h0000_0080, 1'b0, 1'b0, "read_after_abort");
  endtask

  task automatic test_upper_addr;
    do_write(32'h0000_0000, mk_blk(32'h0F0F_0000), "write_b0");
`ifdef MEM_BOUNDS_CHECK_EN
    do_read(32'h0001_0000, 1'b1, 1'b0, "read_oob");
`else
    do_read(32'h0001_0000, 1'b0, 1'b0, "read_alias");
`endif
  endtask

  task automatic test_idle_data;
    n_checks++;
    if (idle_bad != 0) $display("FAIL idle_outputs: got %0d nonzero idle cycles want 0", idle_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_during_wait;
    test_upper_addr;
    test_idle_data;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
